// File: rtl/button_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : button_mode_ctrl
// Description : Set-path front end for the alarm clock. Synchronises and
//               debounces the three raw push-buttons, runs the mode FSM
//               (CLOCK / SET_HOUR / SET_MIN / ALARM_HOUR / ALARM_MIN) and
//               produces the hour/minute step strobes, with auto-repeat while
//               a single up/down button is held and an idle timeout back to
//               CLOCK.
// Ports       : clk        - system clock
//               rst        - synchronous reset, active low
//               btn_mode   - raw mode button (asynchronous, active high)
//               btn_up     - raw increment button (asynchronous, active high)
//               btn_down   - raw decrement button (asynchronous, active high)
//               adjust     - high in any set state
//               alarm_sel  - high in ALARM_HOUR / ALARM_MIN
//               ENTH       - one-cycle hour-step strobe
//               ENTM       - one-cycle minute-step strobe
//               updown     - step direction (1 = decrement), valid with strobes
//               mode_state - current FSM state encoding
// Revision    : 1.0 - initial release
// ============================================================================
module button_mode_ctrl #(
    parameter int DEBOUNCE      = 500000,
    parameter int REPEAT_START  = 50000000,
    parameter int REPEAT_PERIOD = 12500000,
    parameter int TIMEOUT       = 500000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic       adjust,
    output logic       alarm_sel,
    output logic       ENTH,
    output logic       ENTM,
    output logic       updown,
    output logic [2:0] mode_state
);

    // ------------------------------------------------------------------------
    // Widths and constants
    // ------------------------------------------------------------------------
    localparam int DB_W  = $clog2(DEBOUNCE + 1);
    localparam int RP_MX = (REPEAT_START > REPEAT_PERIOD) ? REPEAT_START : REPEAT_PERIOD;
    localparam int RP_W  = $clog2(RP_MX + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [DB_W-1:0] c_DB_LAST = DB_W'(DEBOUNCE - 1);
    localparam logic [RP_W-1:0] c_RS_LAST = RP_W'(REPEAT_START - 1);
    localparam logic [RP_W-1:0] c_RP_LAST = RP_W'(REPEAT_PERIOD - 1);
    localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(TIMEOUT - 1);

    localparam int c_MODE = 0;
    localparam int c_UP   = 1;
    localparam int c_DOWN = 2;

    typedef enum logic [2:0] {
        CLOCK      = 3'd0,
        SET_HOUR   = 3'd1,
        SET_MIN    = 3'd2,
        ALARM_HOUR = 3'd3,
        ALARM_MIN  = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // Button conditioning: 2-flop synchroniser, stability counter, edge detect
    // ------------------------------------------------------------------------
    logic [2:0] w_raw;
    logic [2:0] w_deb;
    logic [2:0] w_press;

    assign w_raw = {btn_down, btn_up, btn_mode};

    for (genvar g = 0; g < 3; g++) begin : g_btn
        logic            r_sync1;
        logic            r_sync2;
        logic            r_deb;
        logic            r_deb_d;
        logic [DB_W-1:0] r_cnt;

        always_ff @(posedge clk) begin
            if (!rst) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
                r_deb   <= 1'b0;
                r_deb_d <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_sync1 <= w_raw[g];
                r_sync2 <= r_sync1;
                r_deb_d <= r_deb;
                // Any return to the accepted level restarts the stability count,
                // so only an uninterrupted run of DEBOUNCE cycles is accepted.
                if (r_sync2 == r_deb) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_DB_LAST) begin
                    r_deb <= ~r_deb;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + DB_W'(1);
                end
            end
        end

        assign w_deb[g]   = r_deb;
        assign w_press[g] = r_deb & ~r_deb_d;
    end

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    state_t          r_state;
    logic            r_adjust;
    logic            r_alarm_sel;
    logic            r_enth;
    logic            r_entm;
    logic            r_updown;
    logic            r_armed;      // a single up/down press was accepted and is still held
    logic            r_rep_dir;    // button owning the repeat: 1 = down
    logic            r_repeating;  // initial delay done, now using the period
    logic [RP_W-1:0] r_rep_cnt;
    logic [TO_W-1:0] r_idle_cnt;

    state_t          w_state_nxt;
    logic            w_adjust_nxt;
    logic            w_alarm_sel_nxt;
    logic            w_enth_nxt;
    logic            w_entm_nxt;
    logic            w_updown_nxt;
    logic            w_armed_nxt;
    logic            w_rep_dir_nxt;
    logic            w_repeating_nxt;
    logic [RP_W-1:0] w_rep_cnt_nxt;
    logic [TO_W-1:0] w_idle_nxt;

    logic            w_up_ok;
    logic            w_dn_ok;
    logic            w_held;
    logic            w_fire;
    logic            w_fire_dir;
    logic [RP_W-1:0] w_rep_last;

    // A press only counts as a step when the other direction is not down;
    // simultaneous presses therefore cancel each other.
    assign w_up_ok    = w_press[c_UP]   & ~w_deb[c_DOWN];
    assign w_dn_ok    = w_press[c_DOWN] & ~w_deb[c_UP];
    assign w_held     = r_rep_dir ? (w_deb[c_DOWN] & ~w_deb[c_UP])
                                  : (w_deb[c_UP]   & ~w_deb[c_DOWN]);
    assign w_rep_last = r_repeating ? c_RP_LAST : c_RS_LAST;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= CLOCK;
            r_adjust    <= 1'b0;
            r_alarm_sel <= 1'b0;
            r_enth      <= 1'b0;
            r_entm      <= 1'b0;
            r_updown    <= 1'b0;
            r_armed     <= 1'b0;
            r_rep_dir   <= 1'b0;
            r_repeating <= 1'b0;
            r_rep_cnt   <= '0;
            r_idle_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_adjust    <= w_adjust_nxt;
            r_alarm_sel <= w_alarm_sel_nxt;
            r_enth      <= w_enth_nxt;
            r_entm      <= w_entm_nxt;
            r_updown    <= w_updown_nxt;
            r_armed     <= w_armed_nxt;
            r_rep_dir   <= w_rep_dir_nxt;
            r_repeating <= w_repeating_nxt;
            r_rep_cnt   <= w_rep_cnt_nxt;
            r_idle_cnt  <= w_idle_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_updown_nxt    = r_updown;
        w_armed_nxt     = r_armed;
        w_rep_dir_nxt   = r_rep_dir;
        w_repeating_nxt = r_repeating;
        w_rep_cnt_nxt   = r_rep_cnt;
        w_idle_nxt      = r_idle_cnt;
        w_fire          = 1'b0;
        w_fire_dir      = 1'b0;

        if (w_press[c_MODE]) begin
            // Mode has priority over any step press in the same cycle.
            unique case (r_state)
                CLOCK:      w_state_nxt = SET_HOUR;
                SET_HOUR:   w_state_nxt = SET_MIN;
                SET_MIN:    w_state_nxt = ALARM_HOUR;
                ALARM_HOUR: w_state_nxt = ALARM_MIN;
                default:    w_state_nxt = CLOCK;
            endcase
            w_armed_nxt     = 1'b0;
            w_repeating_nxt = 1'b0;
            w_rep_cnt_nxt   = '0;
        end else if (r_state == CLOCK) begin
            w_armed_nxt     = 1'b0;
            w_repeating_nxt = 1'b0;
            w_rep_cnt_nxt   = '0;
        end else if (w_up_ok || w_dn_ok) begin
            w_fire          = 1'b1;
            w_fire_dir      = w_dn_ok;
            w_armed_nxt     = 1'b1;
            w_rep_dir_nxt   = w_dn_ok;
            w_repeating_nxt = 1'b0;
            w_rep_cnt_nxt   = '0;
        end else if (r_armed && w_held) begin
            if (r_rep_cnt == w_rep_last) begin
                w_fire          = 1'b1;
                w_fire_dir      = r_rep_dir;
                w_repeating_nxt = 1'b1;
                w_rep_cnt_nxt   = '0;
            end else begin
                w_rep_cnt_nxt   = r_rep_cnt + RP_W'(1);
            end
        end else begin
            // Released, or the other button joined: a fresh press is needed.
            w_armed_nxt     = 1'b0;
            w_repeating_nxt = 1'b0;
            w_rep_cnt_nxt   = '0;
        end

        // Idle timeout. Activity wins over an expiring count.
        if ((|w_press) || w_fire) begin
            w_idle_nxt = '0;
        end else if (r_state == CLOCK) begin
            w_idle_nxt = '0;
        end else if (r_idle_cnt == c_TO_LAST) begin
            w_state_nxt     = CLOCK;
            w_idle_nxt      = '0;
            w_armed_nxt     = 1'b0;
            w_repeating_nxt = 1'b0;
            w_rep_cnt_nxt   = '0;
        end else begin
            w_idle_nxt = r_idle_cnt + TO_W'(1);
        end

        if (w_fire) begin
            w_updown_nxt = w_fire_dir;
        end
        w_enth_nxt      = w_fire && ((r_state == SET_HOUR) || (r_state == ALARM_HOUR));
        w_entm_nxt      = w_fire && ((r_state == SET_MIN)  || (r_state == ALARM_MIN));
        w_adjust_nxt    = (w_state_nxt != CLOCK);
        w_alarm_sel_nxt = (w_state_nxt == ALARM_HOUR) || (w_state_nxt == ALARM_MIN);
    end

    assign adjust     = r_adjust;
    assign alarm_sel  = r_alarm_sel;
    assign ENTH       = r_enth;
    assign ENTM       = r_entm;
    assign updown     = r_updown;
    assign mode_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_button_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_mode_ctrl
// Description : Self-checking bench for button_mode_ctrl. Expected step
//               strobes are queued when stimulus is applied and compared by a
//               monitor when ENTH/ENTM appear; state outputs are checked
//               inline by the scenario tasks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_mode_ctrl;

    localparam int DEBOUNCE      = 4;
    localparam int REPEAT_START  = 20;
    localparam int REPEAT_PERIOD = 5;
    localparam int TIMEOUT       = 50;
    localparam int LAT           = DEBOUNCE + 3;

    logic       clk;
    logic       rst;
    logic       btn_mode;
    logic       btn_up;
    logic       btn_down;
    logic       adjust;
    logic       alarm_sel;
    logic       ENTH;
    logic       ENTM;
    logic       updown;
    logic [2:0] mode_state;

    button_mode_ctrl #(
        .DEBOUNCE      (DEBOUNCE),
        .REPEAT_START  (REPEAT_START),
        .REPEAT_PERIOD (REPEAT_PERIOD),
        .TIMEOUT       (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_mode   (btn_mode),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .adjust     (adjust),
        .alarm_sel  (alarm_sel),
        .ENTH       (ENTH),
        .ENTM       (ENTM),
        .updown     (updown),
        .mode_state (mode_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int   cyc;
        logic is_h;
        logic ud;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks     = 0;
    int   failures   = 0;
    int   strobe_cnt = 0;

    task automatic push_exp(input int c, input logic h, input logic u);
        exp_t e;
        e.cyc  = c;
        e.is_h = h;
        e.ud   = u;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Strobe scoreboard: every strobe must match the head of the queue.
    always @(negedge clk) begin
        if (ENTH || ENTM) begin
            strobe_cnt++;
            checks++;
            if (ENTH && ENTM) begin
                failures++;
                $display("FAIL both_strobes cyc=%0d ENTH=%b ENTM=%b required one-hot", cyc, ENTH, ENTM);
            end else if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_strobe cyc=%0d ENTH=%b ENTM=%b updown=%b required none", cyc, ENTH, ENTM, updown);
            end else begin
                mon_e = sb.pop_front();
                if (cyc !== mon_e.cyc || ENTH !== mon_e.is_h || updown !== mon_e.ud) begin
                    failures++;
                    $display("FAIL strobe cyc=%0d ENTH=%b updown=%b required cyc=%0d ENTH=%b updown=%b",
                             cyc, ENTH, updown, mon_e.cyc, mon_e.is_h, mon_e.ud);
                end
            end
        end
    end

    task automatic test_reset;
        rst = 1'b0; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        tick(2);
        checks++;
        if ({adjust, alarm_sel, ENTH, ENTM, updown, mode_state} !== 8'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b required=00000000", {adjust, alarm_sel, ENTH, ENTM, updown, mode_state});
        end
        rst = 1'b1;
        tick(1);
        checks++;
        if ({adjust, alarm_sel, ENTH, ENTM, updown, mode_state} !== 8'd0) begin
            failures++;
            $display("FAIL post_reset_outputs got=%b required=00000000", {adjust, alarm_sel, ENTH, ENTM, updown, mode_state});
        end
    endtask

    task automatic test_mode_cycle;
        logic [2:0] prev;
        logic [2:0] nxt;
        int         s0;
        s0 = strobe_cnt;
        for (int i = 0; i < 5; i++) begin
            prev = 3'((i) % 5);
            nxt  = 3'((i + 1) % 5);
            btn_mode = 1'b1;
            tick(LAT - 1);
            checks++;
            if (mode_state !== prev) begin
                failures++;
                $display("FAIL mode_early press=%0d got=%0d required=%0d", i, mode_state, prev);
            end
            tick(1);
            checks++;
            if (mode_state !== nxt || adjust !== (nxt != 3'd0) ||
                alarm_sel !== (nxt == 3'd3 || nxt == 3'd4)) begin
                failures++;
                $display("FAIL mode_step press=%0d got state=%0d adjust=%b alarm_sel=%b required state=%0d adjust=%b alarm_sel=%b",
                         i, mode_state, adjust, alarm_sel, nxt, (nxt != 3'd0), (nxt == 3'd3 || nxt == 3'd4));
            end
            btn_mode = 1'b0;
            tick(8);
        end
        checks++;
        if (strobe_cnt !== s0) begin
            failures++;
            $display("FAIL mode_no_strobe got=%0d strobes required=0", strobe_cnt - s0);
        end
    endtask

    task automatic test_step_strobe;
        int s0;
        int m;
        btn_mode = 1'b1;
        tick(LAT);
        btn_mode = 1'b0;
        checks++;
        if (mode_state !== 3'd1) begin
            failures++;
            $display("FAIL enter_set_hour got=%0d required=1", mode_state);
        end
        tick(7);
        s0 = strobe_cnt;
        btn_down = 1'b1;
        tick(3);
        btn_down = 1'b0;
        tick(10);
        checks++;
        if (strobe_cnt !== s0) begin
            failures++;
            $display("FAIL glitch got=%0d strobes required=0", strobe_cnt - s0);
        end
        m = cyc;
        push_exp(m + LAT, 1'b1, 1'b1);
        btn_down = 1'b1;
        tick(10);
        btn_down = 1'b0;
        tick(10);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL down_strobe_missing got=%0d pending required=0", sb.size());
            sb.delete();
        end
        checks++;
        if (updown !== 1'b1) begin
            failures++;
            $display("FAIL updown_hold got=%b required=1", updown);
        end
    endtask

    task automatic test_mode_wins;
        int s0;
        s0 = strobe_cnt;
        btn_mode = 1'b1;
        btn_up   = 1'b1;
        tick(LAT);
        checks++;
        if (mode_state !== 3'd2 || alarm_sel !== 1'b0) begin
            failures++;
            $display("FAIL mode_wins got state=%0d alarm_sel=%b required state=2 alarm_sel=0", mode_state, alarm_sel);
        end
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        tick(10);
        checks++;
        if (strobe_cnt !== s0) begin
            failures++;
            $display("FAIL mode_wins_strobe got=%0d strobes required=0", strobe_cnt - s0);
        end
    endtask

    task automatic test_repeat;
        int q;
        q = cyc;
        push_exp(q + LAT, 1'b0, 1'b0);
        push_exp(q + LAT + REPEAT_START, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++)
            push_exp(q + LAT + REPEAT_START + k * REPEAT_PERIOD, 1'b0, 1'b0);
        btn_up = 1'b1;
        tick(40);
        btn_up = 1'b0;
        tick(15);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL repeat_missing got=%0d pending required=0", sb.size());
            sb.delete();
        end
        checks++;
        if (updown !== 1'b0 || mode_state !== 3'd2) begin
            failures++;
            $display("FAIL repeat_after got updown=%b state=%0d required updown=0 state=2", updown, mode_state);
        end
    endtask

    task automatic test_both_held;
        int s0;
        s0 = strobe_cnt;
        btn_up   = 1'b1;
        btn_down = 1'b1;
        tick(15);
        btn_down = 1'b0;
        tick(15);
        btn_up = 1'b0;
        tick(10);
        checks++;
        if (strobe_cnt !== s0 || mode_state !== 3'd2) begin
            failures++;
            $display("FAIL both_held got strobes=%0d state=%0d required strobes=0 state=2", strobe_cnt - s0, mode_state);
        end
    endtask

    task automatic test_timeout;
        for (int i = 0; i < 2; i++) begin
            btn_mode = 1'b1;
            tick(LAT);
            btn_mode = 1'b0;
            checks++;
            if (mode_state !== 3'(3 + i) || alarm_sel !== 1'b1) begin
                failures++;
                $display("FAIL alarm_enter got state=%0d alarm_sel=%b required state=%0d alarm_sel=1", mode_state, alarm_sel, 3 + i);
            end
            if (i == 0) tick(7);
        end
        tick(TIMEOUT - 1);
        checks++;
        if (mode_state !== 3'd4) begin
            failures++;
            $display("FAIL timeout_early got=%0d required=4", mode_state);
        end
        tick(1);
        checks++;
        if (mode_state !== 3'd0 || adjust !== 1'b0 || alarm_sel !== 1'b0) begin
            failures++;
            $display("FAIL timeout got state=%0d adjust=%b alarm_sel=%b required state=0 adjust=0 alarm_sel=0", mode_state, adjust, alarm_sel);
        end
        tick(5);
    endtask

    task automatic test_reset_mid_repeat;
        int u;
        btn_mode = 1'b1;
        tick(LAT);
        btn_mode = 1'b0;
        tick(7);
        u = cyc;
        push_exp(u + LAT, 1'b1, 1'b0);
        push_exp(u + LAT + REPEAT_START, 1'b1, 1'b0);
        btn_up = 1'b1;
        tick(30);
        rst    = 1'b0;
        btn_up = 1'b0;
        tick(1);
        checks++;
        if ({adjust, alarm_sel, ENTH, ENTM, updown, mode_state} !== 8'd0) begin
            failures++;
            $display("FAIL reset_mid_repeat got=%b required=00000000", {adjust, alarm_sel, ENTH, ENTM, updown, mode_state});
        end
        tick(1);
        rst = 1'b1;
        tick(10);
        checks++;
        if (sb.size() != 0 || mode_state !== 3'd0) begin
            failures++;
            $display("FAIL reset_repeat_after got pending=%0d state=%0d required pending=0 state=0", sb.size(), mode_state);
            sb.delete();
        end
    endtask

    initial begin
        test_reset();
        test_mode_cycle();
        test_step_strobe();
        test_mode_wins();
        test_repeat();
        test_both_held();
        test_timeout();
        test_reset_mid_repeat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
